// File: rtl/pong_ball_control_if.sv
// Signal bundle between the pong ball engine and the rest of the playfield.
// The master side drives the game/paddle/counter inputs, and the slave side is the ball engine.
interface pong_ball_control_if;
  logic       i_Game_Start;
  logic [5:0] i_ColCount_Div;
  logic [5:0] i_RowCount_Div;
  logic [5:0] i_Paddle_Y_P1;
  logic [5:0] i_Paddle_Y_P2;
  logic       o_DrawBall;
  logic [5:0] o_Ball_X;
  logic [5:0] o_Ball_Y;
  logic       o_P1_Score;
  logic       o_P2_Score;

  modport master (
    output i_Game_Start, i_ColCount_Div, i_RowCount_Div, i_Paddle_Y_P1, i_Paddle_Y_P2,
    input  o_DrawBall, o_Ball_X, o_Ball_Y, o_P1_Score, o_P2_Score
  );

  modport slave (
    input  i_Game_Start, i_ColCount_Div, i_RowCount_Div, i_Paddle_Y_P1, i_Paddle_Y_P2,
    output o_DrawBall, o_Ball_X, o_Ball_Y, o_P1_Score, o_P2_Score
  );
endinterface

// File: rtl/pong_ball_control.sv
// Pong ball engine: steps the ball on the tile grid, bounces off walls and paddles, and pulses a score on a miss.
// Optional PONG_BALL_SPEEDUP_EN: each paddle hit halves the step period (saturates after 3 hits).
module pong_ball_control #(
  parameter int unsigned c_GAME_WINDOW_WIDTH  = 40,
  parameter int unsigned c_GAME_WINDOW_HEIGHT = 30,
  parameter int unsigned c_PADDLE_HEIGHT      = 6,
  parameter int unsigned c_PADDLE_COL_P1      = 0,
  parameter int unsigned c_PADDLE_COL_P2      = 39,
  parameter int unsigned c_BALL_SPEED_CYCLES  = 1250000
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  pong_ball_control_if.slave  bus
);

  localparam int unsigned CNT_W = (c_BALL_SPEED_CYCLES > 1) ? $clog2(c_BALL_SPEED_CYCLES) : 1;
  localparam logic [5:0]  X_CENTRE = 6'(c_GAME_WINDOW_WIDTH / 2);
  localparam logic [5:0]  Y_CENTRE = 6'(c_GAME_WINDOW_HEIGHT / 2);
  localparam logic [5:0]  Y_BOTTOM = 6'(c_GAME_WINDOW_HEIGHT - 1);
  localparam logic [5:0]  X_HIT_P1 = 6'(c_PADDLE_COL_P1 + 1);
  localparam logic [5:0]  X_HIT_P2 = 6'(c_PADDLE_COL_P2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCORED
  } state_e;

  state_e           state_q;
  logic [5:0]       ball_x_q;
  logic [5:0]       ball_y_q;
  logic             dir_right_q;
  logic             dir_down_q;
  logic [CNT_W-1:0] cnt_q;
  logic             draw_q;
  logic             p1_score_q;
  logic             p2_score_q;
  logic [CNT_W-1:0] top_c;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [1:0]  hit_q;
  int unsigned period_c;

  // Period shrinks with hit count; a period that shifts down to zero still means one clock per step.
  always_comb begin
    period_c = c_BALL_SPEED_CYCLES >> hit_q;
    top_c    = (period_c == 0) ? '0 : CNT_W'(period_c - 1);
  end
`else
  assign top_c = CNT_W'(c_BALL_SPEED_CYCLES - 1);
`endif

  logic       tick_c;
  logic       at_p1_c;
  logic       at_p2_c;
  logic       p1_cover_c;
  logic       p2_cover_c;
  logic [6:0] y7_c;
  logic [6:0] pad1_top_c;
  logic [6:0] pad2_top_c;

  // Paddle coverage is checked at 7 bits, so top row + height cannot wrap.
  assign y7_c       = {1'b0, ball_y_q};
  assign pad1_top_c = {1'b0, bus.i_Paddle_Y_P1};
  assign pad2_top_c = {1'b0, bus.i_Paddle_Y_P2};
  assign p1_cover_c = (y7_c >= pad1_top_c) && (y7_c <= pad1_top_c + 7'(c_PADDLE_HEIGHT));
  assign p2_cover_c = (y7_c >= pad2_top_c) && (y7_c <= pad2_top_c + 7'(c_PADDLE_HEIGHT));

  assign tick_c  = (state_q == ST_PLAY) && (cnt_q == top_c);
  assign at_p2_c = dir_right_q  && (ball_x_q == X_HIT_P2);
  assign at_p1_c = !dir_right_q && (ball_x_q == X_HIT_P1);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= X_CENTRE;
      ball_y_q    <= Y_CENTRE;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      cnt_q       <= '0;
      draw_q      <= 1'b0;
      p1_score_q  <= 1'b0;
      p2_score_q  <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
      hit_q       <= 2'd0;
`endif
    end else begin
      draw_q     <= (bus.i_ColCount_Div == ball_x_q) && (bus.i_RowCount_Div == ball_y_q);
      p1_score_q <= 1'b0;
      p2_score_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (bus.i_Game_Start) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (!tick_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
            if (at_p2_c && !p2_cover_c) begin
              // P2 missed: serve back toward P2
              state_q     <= ST_SCORED;
              p1_score_q  <= 1'b1;
              ball_x_q    <= X_CENTRE;
              ball_y_q    <= Y_CENTRE;
              dir_down_q  <= 1'b1;
              dir_right_q <= 1'b1;
            end else if (at_p1_c && !p1_cover_c) begin
              state_q     <= ST_SCORED;
              p2_score_q  <= 1'b1;
              ball_x_q    <= X_CENTRE;
              ball_y_q    <= Y_CENTRE;
              dir_down_q  <= 1'b1;
              dir_right_q <= 1'b0;
            end else begin
              if (dir_down_q && (ball_y_q == Y_BOTTOM)) begin
                dir_down_q <= 1'b0;
              end else if (!dir_down_q && (ball_y_q == 6'd0)) begin
                dir_down_q <= 1'b1;
              end else begin
                ball_y_q <= dir_down_q ? ball_y_q + 6'd1 : ball_y_q - 6'd1;
              end

              if (at_p2_c || at_p1_c) begin
                dir_right_q <= !dir_right_q;
`ifdef PONG_BALL_SPEEDUP_EN
                if (hit_q != 2'd3) hit_q <= hit_q + 2'd1;
`endif
              end else begin
                ball_x_q <= dir_right_q ? ball_x_q + 6'd1 : ball_x_q - 6'd1;
              end
            end
          end
        end
        ST_SCORED: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
          hit_q   <= 2'd0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_DrawBall = draw_q;
  assign bus.o_Ball_X   = ball_x_q;
  assign bus.o_Ball_Y   = ball_y_q;
  assign bus.o_P1_Score = p1_score_q;
  assign bus.o_P2_Score = p2_score_q;

endmodule

// File: tb/tb_pong_ball_control.sv
// Bench for pong_ball_control: directed playfield scenarios plus random play against a tile-level reference model.
module tb_pong_ball_control;

  localparam int SPEED = 4;
  localparam int W     = 40;
  localparam int H     = 30;
  localparam int PH    = 6;
  localparam int COL1  = 0;
  localparam int COL2  = 39;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pong_ball_control_if ifc ();

  pong_ball_control #(
    .c_GAME_WINDOW_WIDTH (W),
    .c_GAME_WINDOW_HEIGHT(H),
    .c_PADDLE_HEIGHT     (PH),
    .c_PADDLE_COL_P1     (COL1),
    .c_PADDLE_COL_P2     (COL2),
    .c_BALL_SPEED_CYCLES (SPEED)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting, 1 = playing, 2 = score cycle; dx/dy are +1/-1.
  typedef struct {
    int x, y, dx, dy, cnt, mode, hits;
    bit draw, s1, s2;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.x = W / 2; r.y = H / 2; r.dx = 1; r.dy = 1; r.cnt = 0; r.mode = 0; r.hits = 0;
    r.draw = 0; r.s1 = 0; r.s2 = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t c, bit start, int col, int row, int p1y, int p2y);
    mdl_t n;
    int   per;
    bit   miss2, miss1;
    n = c;
    n.draw = (col == c.x) && (row == c.y);
    n.s1 = 0;
    n.s2 = 0;
    if (c.mode == 0) begin
      n.cnt = 0;
      if (start) n.mode = 1;
    end else if (c.mode == 2) begin
      n.mode = 0; n.cnt = 0; n.hits = 0;
    end else begin
`ifdef PONG_BALL_SPEEDUP_EN
      per = SPEED >> c.hits;
`else
      per = SPEED;
`endif
      if (per < 1) per = 1;
      if (c.cnt < per - 1) begin
        n.cnt = c.cnt + 1;
      end else begin
        n.cnt = 0;
        miss2 = (c.dx > 0) && (c.x == COL2 - 1) && !((c.y >= p2y) && (c.y <= p2y + PH));
        miss1 = (c.dx < 0) && (c.x == COL1 + 1) && !((c.y >= p1y) && (c.y <= p1y + PH));
        if (miss2 || miss1) begin
          n.mode = 2; n.x = W / 2; n.y = H / 2; n.dy = 1;
          n.dx = miss2 ? 1 : -1;
          n.s1 = miss2;
          n.s2 = miss1;
        end else begin
          if ((c.dy > 0 && c.y == H - 1) || (c.dy < 0 && c.y == 0)) n.dy = -c.dy;
          else n.y = c.y + c.dy;
          if ((c.dx > 0 && c.x == COL2 - 1) || (c.dx < 0 && c.x == COL1 + 1)) begin
            n.dx = -c.dx;
            if (c.hits < 3) n.hits = c.hits + 1;
          end else begin
            n.x = c.x + c.dx;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else m <= mdl_next(m, ifc.i_Game_Start, int'(ifc.i_ColCount_Div), int'(ifc.i_RowCount_Div),
                       int'(ifc.i_Paddle_Y_P1), int'(ifc.i_Paddle_Y_P2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_fresh();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.i_Game_Start   = 1'b0;
    ifc.i_ColCount_Div = 6'd0;
    ifc.i_RowCount_Div = 6'd0;
    ifc.i_Paddle_Y_P1  = 6'd22;
    ifc.i_Paddle_Y_P2  = 6'd22;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15) begin
      bad++; $display("FAIL reset_pos: got (%0d,%0d) want (20,15)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
    total++;
    if (ifc.o_DrawBall !== 1'b0 || ifc.o_P1_Score !== 1'b0 || ifc.o_P2_Score !== 1'b0) begin
      bad++; $display("FAIL reset_flags: draw=%b p1=%b p2=%b want 0 0 0",
                      ifc.o_DrawBall, ifc.o_P1_Score, ifc.o_P2_Score);
    end
    step();
    rst_n = 1'b1;
    step();
    ifc.i_ColCount_Div = 6'd20;
    ifc.i_RowCount_Div = 6'd15;
    step();
    total++;
    if (ifc.o_DrawBall !== 1'b1) begin
      bad++; $display("FAIL draw_centre: got %b want 1", ifc.o_DrawBall);
    end
    ifc.i_ColCount_Div = 6'd21;
    step();
    total++;
    if (ifc.o_DrawBall !== 1'b0) begin
      bad++; $display("FAIL draw_one_cycle: got %b want 0", ifc.o_DrawBall);
    end
    repeat (10) step();
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15 || ifc.o_P1_Score !== 1'b0) begin
      bad++; $display("FAIL idle_hold: got (%0d,%0d) p1=%b want (20,15) 0",
                      ifc.o_Ball_X, ifc.o_Ball_Y, ifc.o_P1_Score);
    end
  endtask

  // Start play with both paddles at 22 and walk to tick 18.
  task automatic test_wall_bounce();
    int ys[1:18];
    int x18;
    reset_fresh();
    ifc.i_Paddle_Y_P1 = 6'd22;
    ifc.i_Paddle_Y_P2 = 6'd22;
    ifc.i_Game_Start  = 1'b1;
    step();
    x18 = -1;
    for (int k = 1; k <= 18; k++) begin
      repeat (SPEED - 1) step();
      total++;
      if (int'(ifc.o_Ball_Y) !== m.y || int'(ifc.o_Ball_X) !== m.x) begin
        bad++; $display("FAIL pre_tick_%0d: got (%0d,%0d) want (%0d,%0d)",
                        k, ifc.o_Ball_X, ifc.o_Ball_Y, m.x, m.y);
      end
      step();
      ys[k] = int'(ifc.o_Ball_Y);
      if (k == 18) x18 = int'(ifc.o_Ball_X);
    end
    total++;
    if (ys[14] !== 29) begin bad++; $display("FAIL y_tick14: got %0d want 29", ys[14]); end
    total++;
    if (ys[15] !== 29) begin bad++; $display("FAIL y_tick15: got %0d want 29", ys[15]); end
    total++;
    if (ys[16] !== 28) begin bad++; $display("FAIL y_tick16: got %0d want 28", ys[16]); end
    total++;
    if (x18 !== 38 || ys[18] !== 26) begin
      bad++; $display("FAIL tick18: got (%0d,%0d) want (38,26)", x18, ys[18]);
    end
  endtask

  task automatic test_paddle_hit();
    repeat (SPEED) step();
    total++;
    if (ifc.o_Ball_X !== 6'd38 || ifc.o_Ball_Y !== 6'd25 || ifc.o_P1_Score !== 1'b0) begin
      bad++; $display("FAIL hit_tick19: got (%0d,%0d) p1=%b want (38,25) 0",
                      ifc.o_Ball_X, ifc.o_Ball_Y, ifc.o_P1_Score);
    end
    repeat (SPEED) step();
    total++;
    if (ifc.o_Ball_X !== 6'd37 || ifc.o_Ball_Y !== 6'd24) begin
      bad++; $display("FAIL hit_tick20: got (%0d,%0d) want (37,24)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
  endtask

  task automatic test_miss();
    reset_fresh();
    ifc.i_Paddle_Y_P1 = 6'd22;
    ifc.i_Paddle_Y_P2 = 6'd0;
    ifc.i_Game_Start  = 1'b1;
    step();
    repeat (18 * SPEED) step();
    total++;
    if (ifc.o_Ball_X !== 6'd38 || ifc.o_Ball_Y !== 6'd26) begin
      bad++; $display("FAIL miss_tick18: got (%0d,%0d) want (38,26)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
    ifc.i_Game_Start = 1'b0;
    repeat (SPEED - 1) step();
    total++;
    if (ifc.o_P1_Score !== 1'b0) begin bad++; $display("FAIL miss_early: p1=%b want 0", ifc.o_P1_Score); end
    step();
    total++;
    if (ifc.o_P1_Score !== 1'b1 || ifc.o_P2_Score !== 1'b0) begin
      bad++; $display("FAIL miss_pulse: p1=%b p2=%b want 1 0", ifc.o_P1_Score, ifc.o_P2_Score);
    end
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15) begin
      bad++; $display("FAIL miss_centre: got (%0d,%0d) want (20,15)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
    step();
    total++;
    if (ifc.o_P1_Score !== 1'b0 || ifc.o_P2_Score !== 1'b0) begin
      bad++; $display("FAIL miss_width: p1=%b p2=%b want 0 0", ifc.o_P1_Score, ifc.o_P2_Score);
    end
    repeat (3 * SPEED) step();
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15) begin
      bad++; $display("FAIL miss_idle: got (%0d,%0d) want (20,15)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
  endtask

  task automatic test_async_reset();
    reset_fresh();
    ifc.i_Paddle_Y_P1 = 6'd22;
    ifc.i_Paddle_Y_P2 = 6'd22;
    ifc.i_Game_Start  = 1'b1;
    repeat (1 + 2 * SPEED) step();
    ifc.i_ColCount_Div = 6'(m.x);
    ifc.i_RowCount_Div = 6'(m.y);
    step();
    total++;
    if (ifc.o_DrawBall !== 1'b1 || ifc.o_Ball_X !== 6'd22) begin
      bad++; $display("FAIL areset_pre: draw=%b x=%0d want 1 22", ifc.o_DrawBall, ifc.o_Ball_X);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15 || ifc.o_DrawBall !== 1'b0) begin
      bad++; $display("FAIL areset_now: got (%0d,%0d) draw=%b want (20,15) 0",
                      ifc.o_Ball_X, ifc.o_Ball_Y, ifc.o_DrawBall);
    end
    ifc.i_ColCount_Div = 6'd0;
    ifc.i_RowCount_Div = 6'd0;
    #2 rst_n = 1'b1;
    repeat (SPEED) step();
    total++;
    if (ifc.o_Ball_X !== 6'd20 || ifc.o_Ball_Y !== 6'd15) begin
      bad++; $display("FAIL areset_wait: got (%0d,%0d) want (20,15)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
    step();
    total++;
    if (ifc.o_Ball_X !== 6'd21 || ifc.o_Ball_Y !== 6'd16) begin
      bad++; $display("FAIL areset_resume: got (%0d,%0d) want (21,16)", ifc.o_Ball_X, ifc.o_Ball_Y);
    end
  endtask

  task automatic test_random_play();
    int errs;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 48 == 0) begin
        ifc.i_Paddle_Y_P1 = 6'($urandom_range(0, 29));
        ifc.i_Paddle_Y_P2 = 6'($urandom_range(0, 29));
      end
      ifc.i_Game_Start   = ($urandom_range(0, 15) != 0);
      ifc.i_ColCount_Div = ($urandom_range(0, 1) != 0) ? 6'(m.x) : 6'($urandom_range(0, 63));
      ifc.i_RowCount_Div = ($urandom_range(0, 1) != 0) ? 6'(m.y) : 6'($urandom_range(0, 63));
      step();
      total++;
      if (int'(ifc.o_Ball_X) !== m.x || int'(ifc.o_Ball_Y) !== m.y) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_pos cyc %0d: got (%0d,%0d) want (%0d,%0d)",
                                i, ifc.o_Ball_X, ifc.o_Ball_Y, m.x, m.y);
      end
      total++;
      if (ifc.o_DrawBall !== m.draw || ifc.o_P1_Score !== m.s1 || ifc.o_P2_Score !== m.s2) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_flags cyc %0d: got draw=%b p1=%b p2=%b want %b %b %b",
                                i, ifc.o_DrawBall, ifc.o_P1_Score, ifc.o_P2_Score, m.draw, m.s1, m.s2);
      end
      total++;
      if (ifc.o_P1_Score === 1'b1 && ifc.o_P2_Score === 1'b1) begin
        bad++; errs++;
        $display("FAIL rand_both_scores cyc %0d: got p1=1 p2=1 want at most one", i);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wall_bounce();
    test_paddle_hit();
    test_miss();
    test_async_reset();
    test_random_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
